// File: rtl/phrase_pkg.sv
// Shared phrase definitions: byte ROMs, failure tables, FSM states, select decode.
// Latency: none (constants and pure functions only).
// Backpressure: n/a; also used by the phrase generator so both ends agree byte-for-byte.
package phrase_pkg;

    localparam int PHR_A_LEN = 9;
    localparam int PHR_B_LEN = 7;

    // "Guatemala"
    localparam logic [0:PHR_A_LEN-1][7:0] PHR_A_ROM = {
        8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61
    };

    // "QQuetza"
    localparam logic [0:PHR_B_LEN-1][7:0] PHR_B_ROM = {
        8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61
    };

    // Fallback positions on mismatch; only "QQ" self-overlaps (third Q keeps index 2).
    localparam logic [0:PHR_A_LEN-1][3:0] PHR_A_FAIL = '0;
    localparam logic [0:PHR_B_LEN-1][3:0] PHR_B_FAIL = {
        4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0
    };

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_MATCH,
        ST_LOCK
    } state_t;

    typedef enum logic {
        PHR_A,
        PHR_B
    } phr_id_t;

    // 00/11 -> Guatemala, 01/10 -> QQuetza
    function automatic phr_id_t sel_to_phr(input logic [1:0] sel);
        return (sel[0] ^ sel[1]) ? PHR_B : PHR_A;
    endfunction

    function automatic logic [3:0] phr_len(input phr_id_t id);
        return (id == PHR_B) ? 4'(PHR_B_LEN) : 4'(PHR_A_LEN);
    endfunction

    // Out-of-range positions read as 0x00, which never matches a phrase byte.
    function automatic logic [7:0] phr_byte(input phr_id_t id, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (id == PHR_B) begin
            for (int i = 0; i < PHR_B_LEN; i++) begin
                if (idx == 4'(i)) b = PHR_B_ROM[i];
            end
        end else begin
            for (int i = 0; i < PHR_A_LEN; i++) begin
                if (idx == 4'(i)) b = PHR_A_ROM[i];
            end
        end
        return b;
    endfunction

    function automatic logic [3:0] phr_fail(input phr_id_t id, input logic [3:0] idx);
        logic [3:0] f;
        f = 4'd0;
        if (id == PHR_B) begin
            for (int i = 0; i < PHR_B_LEN; i++) begin
                if (idx == 4'(i)) f = PHR_B_FAIL[i];
            end
        end else begin
            for (int i = 0; i < PHR_A_LEN; i++) begin
                if (idx == 4'(i)) f = PHR_A_FAIL[i];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/chip_sp_phrase_detector_rom_cmp.sv
// Phrase ROM lookup at index and at fail[index], plus byte compares (PHRASE_CASE_FOLD_EN folds letter case).
// Latency: purely combinational.
// Backpressure: none; qualification by data_valid happens in the caller.
module phrase_rom_cmp
    import phrase_pkg::*;
(
    input  logic       phr_b_i,
    input  logic [3:0] idx_i,
    input  logic [7:0] byte_i,
    output logic       exp_hit_o,
    output logic       fail_hit_o,
    output logic       first_hit_o,
    output logic [3:0] fail_idx_o
);

`ifdef PHRASE_CASE_FOLD_EN
    // Letters only: clearing bit 5 maps a-z onto A-Z; other bytes pass unchanged.
    function automatic logic [7:0] fold(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b & 8'hDF;
        return b;
    endfunction

    function automatic logic byte_eq(input logic [7:0] a, input logic [7:0] b);
        return fold(a) == fold(b);
    endfunction
`else
    function automatic logic byte_eq(input logic [7:0] a, input logic [7:0] b);
        return a == b;
    endfunction
`endif

    phr_id_t phr;
    assign phr = phr_b_i ? PHR_B : PHR_A;

    // Three parallel compares feed the FSM's advance / fallback decision.
    always_comb begin
        fail_idx_o  = phr_fail(phr, idx_i);
        exp_hit_o   = byte_eq(byte_i, phr_byte(phr, idx_i));
        fail_hit_o  = byte_eq(byte_i, phr_byte(phr, fail_idx_o));
        first_hit_o = byte_eq(byte_i, phr_byte(phr, 4'd0));
    end

endmodule

// File: rtl/chip_sp_phrase_detector.sv
// Phrase detector: recognises Guatemala / QQuetza, tracks lock, flags framing errors, counts matches.
// Latency: all outputs registered, one cycle after the deciding byte. Build option: PHRASE_CASE_FOLD_EN.
// Backpressure: none; always accepts, bytes qualified by data_valid; select change aborts the phrase.
module chip_sp_phrase_detector
    import phrase_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       select,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             match,
    output logic             locked,
    output logic             frame_err,
    output logic [3:0]       index,
    output logic [CNT_W-1:0] match_count
);

    state_t           state_q, state_d;
    logic [1:0]       sel_q;
    logic [3:0]       idx_q, idx_d;
    logic             locked_q, locked_d;
    logic             match_q, match_d;
    logic             ferr_q, ferr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    phr_id_t    phr_cur;
    logic       sel_chg;
    logic [3:0] len_cur;
    logic       exp_hit, fail_hit, first_hit;
    logic [3:0] fail_idx;

    // Equivalent select codes (00/11, 01/10) decode to the same phrase, so they never abort.
    assign phr_cur = sel_to_phr(sel_q);
    assign sel_chg = (sel_to_phr(select) != phr_cur);
    assign len_cur = phr_len(phr_cur);

    phrase_rom_cmp u_rom_cmp (
        .phr_b_i     (phr_cur == PHR_B),
        .idx_i       (idx_q),
        .byte_i      (data_in),
        .exp_hit_o   (exp_hit),
        .fail_hit_o  (fail_hit),
        .first_hit_o (first_hit),
        .fail_idx_o  (fail_idx)
    );

    // Next-state: select abort, advance/complete on hit, fail-table fallback on mismatch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        locked_d = locked_q;
        match_d  = 1'b0;
        ferr_d   = 1'b0;
        cnt_d    = cnt_q;

        if (sel_chg) begin
            state_d  = ST_HUNT;
            idx_d    = 4'd0;
            locked_d = 1'b0;
        end else if (data_valid) begin
            if (exp_hit) begin
                if (idx_q == len_cur - 4'd1) begin
                    match_d  = 1'b1;
                    idx_d    = 4'd0;
                    locked_d = 1'b1;
                    state_d  = ST_LOCK;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_MATCH;
                end
            end else begin
                if (fail_hit)       idx_d = fail_idx + 4'd1;
                else if (first_hit) idx_d = 4'd1;
                else                idx_d = 4'd0;
                if (locked_q) begin
                    ferr_d   = 1'b1;
                    locked_d = 1'b0;
                end
                state_d = (idx_d == 4'd0) ? ST_HUNT : ST_MATCH;
            end
        end
    end

    // State and output registers; synchronous reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_HUNT;
            sel_q    <= 2'b00;
            idx_q    <= 4'd0;
            locked_q <= 1'b0;
            match_q  <= 1'b0;
            ferr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= select;
            idx_q    <= idx_d;
            locked_q <= locked_d;
            match_q  <= match_d;
            ferr_q   <= ferr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign match       = match_q;
    assign locked      = locked_q;
    assign frame_err   = ferr_q;
    assign index       = idx_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_chip_sp_phrase_detector.sv
// Testbench for chip_sp_phrase_detector: directed scenarios plus randomized stream against a string-level model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_chip_sp_phrase_detector;

    localparam int CW = 4;  // small counter so saturation is reachable

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    select;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          match, locked, frame_err;
    logic [3:0]    index;
    logic [CW-1:0] match_count;

    chip_sp_phrase_detector #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .select      (select),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .match       (match),
        .locked      (locked),
        .frame_err   (frame_err),
        .index       (index),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    string PA = "Guatemala";
    string PB = "QQuetza";

    // Reference model: window of recent bytes; index = longest suffix that is a phrase prefix.
    logic [1:0]   m_sel;
    byte unsigned m_win[$];
    logic         m_locked, m_match, m_ferr;
    int           m_idx, m_cnt;

    wire [CW+6:0] obs = {match, locked, frame_err, index, match_count};

    function automatic logic [CW+6:0] expv();
        logic [3:0]    i4;
        logic [CW-1:0] c;
        i4 = m_idx[3:0];
        c  = m_cnt[CW-1:0];
        return {m_match, m_locked, m_ferr, i4, c};
    endfunction

    function automatic byte unsigned ph(input bit pb, input int i);
        return pb ? PB[i] : PA[i];
    endfunction

    function automatic int plen(input bit pb);
        return pb ? PB.len() : PA.len();
    endfunction

`ifdef PHRASE_CASE_FOLD_EN
    function automatic byte unsigned upc(input byte unsigned c);
        if (c >= 8'd97 && c <= 8'd122) return c - 8'd32;
        return c;
    endfunction

    function automatic bit chr_eq(input byte unsigned a, input byte unsigned b);
        return upc(a) == upc(b);
    endfunction
`else
    function automatic bit chr_eq(input byte unsigned a, input byte unsigned b);
        return a == b;
    endfunction
`endif

    task automatic drive(input logic rst, input logic [1:0] sel, input logic [7:0] dat, input logic vld);
        bit pb;
        bit ok;
        int k;
        int n;
        reset      = rst;
        select     = sel;
        data_in    = dat;
        data_valid = vld;
        @(posedge clk);
        m_match = 1'b0;
        m_ferr  = 1'b0;
        if (rst) begin
            m_sel = 2'b00;
            m_win.delete();
            m_locked = 1'b0;
            m_idx = 0;
            m_cnt = 0;
        end else begin
            pb = ^m_sel;
            if ((^sel) != pb) begin
                m_win.delete();
                m_locked = 1'b0;
                m_idx = 0;
            end else if (vld) begin
                m_win.push_back(dat);
                if (m_win.size() > plen(pb)) void'(m_win.pop_front());
                n = m_win.size();
                k = 0;
                for (int l = n; l >= 1 && k == 0; l--) begin
                    ok = 1'b1;
                    for (int j = 0; j < l; j++)
                        if (!chr_eq(m_win[n-l+j], ph(pb, j))) ok = 1'b0;
                    if (ok) k = l;
                end
                if (k == plen(pb)) begin
                    m_match = 1'b1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    m_locked = 1'b1;
                    m_win.delete();
                    m_idx = 0;
                end else begin
                    if (k != m_idx + 1 && m_locked) begin
                        m_ferr   = 1'b1;
                        m_locked = 1'b0;
                    end
                    m_idx = k;
                end
            end
            m_sel = sel;
        end
        #1;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        drive(1'b1, sel, 8'h00, 1'b0);
        drive(1'b0, sel, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b00, 8'h47, 1'b1);
        drive(1'b1, 2'b01, 8'h51, 1'b1);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs); end
        for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, PA[i], 1'b1);
        total++;
        if (index !== 4'd4) begin bad++; $display("FAIL reset_pre_index got=%0d exp=4", index); end
        drive(1'b1, 2'b01, 8'h65, 1'b1);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_mid_phrase got=%h exp=0", obs); end
    endtask

    task automatic test_phrase_a();
        do_reset(2'b00);
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 2'b00, PA[i % 9], 1'b1);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL a_model[%0d] got=%h exp=%h", i, obs, expv()); end
            total++;
            if (match !== (i == 8 || i == 17)) begin bad++; $display("FAIL a_match[%0d] got=%b", i, match); end
            total++;
            if (locked !== (i >= 8)) begin bad++; $display("FAIL a_locked[%0d] got=%b", i, locked); end
        end
        total++;
        if (match_count !== 4'd2) begin bad++; $display("FAIL a_count got=%0d exp=2", match_count); end
    endtask

    task automatic test_phrase_b_qqq();
        logic [7:0] seq [8] = '{8'h51, 8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
        do_reset(2'b01);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b01, seq[i], 1'b1);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL qqq_model[%0d] got=%h exp=%h", i, obs, expv()); end
            if (i == 2) begin
                total++;
                if (index !== 4'd2) begin bad++; $display("FAIL qqq_index got=%0d exp=2", index); end
            end
        end
        total++;
        if (match !== 1'b1 || match_count !== 4'd1) begin
            bad++; $display("FAIL qqq_match got=%b/%0d exp=1/1", match, match_count);
        end
    endtask

    task automatic test_frame_err();
        do_reset(2'b00);
        for (int i = 0; i < 9; i++) drive(1'b0, 2'b00, PA[i], 1'b1);
        drive(1'b0, 2'b00, 8'h47, 1'b1);
        drive(1'b0, 2'b00, 8'h58, 1'b1);
        total++;
        if ({frame_err, locked, index} !== {1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL ferr_pulse got=%b/%b/%0d exp=1/0/0", frame_err, locked, index);
        end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL ferr_model got=%h exp=%h", obs, expv()); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 2'b00, PA[i], 1'b1);
            if (i == 0) begin
                total++;
                if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
            end
        end
        total++;
        if ({match, locked} !== 2'b11) begin bad++; $display("FAIL ferr_relock got=%b exp=11", {match, locked}); end
    endtask

    task automatic test_valid_gaps();
        logic [3:0] prev;
        do_reset(2'b10);
        for (int i = 0; i < 14; i++) begin
            prev = index;
            if (i % 2 == 0) drive(1'b0, 2'b10, PB[i/2], 1'b1);
            else            drive(1'b0, 2'b10, 8'($urandom), 1'b0);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL gap_model[%0d] got=%h exp=%h", i, obs, expv()); end
            if (i % 2 == 1) begin
                total++;
                if (index !== prev || match !== 1'b0) begin
                    bad++; $display("FAIL gap_idle[%0d] got=%0d/%b exp=%0d/0", i, index, match, prev);
                end
            end
            if (i == 12) begin
                total++;
                if (match !== 1'b1) begin bad++; $display("FAIL gap_match got=%b exp=1", match); end
            end
        end
        total++;
        if (match_count !== 4'd1) begin bad++; $display("FAIL gap_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_select_change();
        do_reset(2'b00);
        for (int i = 0; i < 9; i++) drive(1'b0, 2'b00, PA[i], 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'b00, PA[i], 1'b1);
        total++;
        if (index !== 4'd5 || locked !== 1'b1) begin
            bad++; $display("FAIL sel_pre got=%0d/%b exp=5/1", index, locked);
        end
        drive(1'b0, 2'b10, 8'h6D, 1'b1);
        total++;
        if ({index, locked, frame_err, match_count} !== {4'd0, 1'b0, 1'b0, 4'd1}) begin
            bad++; $display("FAIL sel_abort got=%0d/%b/%b/%0d exp=0/0/0/1", index, locked, frame_err, match_count);
        end
        for (int i = 0; i < 7; i++) drive(1'b0, 2'b10, PB[i], 1'b1);
        total++;
        if (match !== 1'b1 || match_count !== 4'd2) begin
            bad++; $display("FAIL sel_b_match got=%b/%0d exp=1/2", match, match_count);
        end
    endtask

    task automatic test_case_fold();
        string up;
        up = "GUATEMALA";
        do_reset(2'b00);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 2'b00, up[i], 1'b1);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL fold_model[%0d] got=%h exp=%h", i, obs, expv()); end
        end
        total++;
`ifdef PHRASE_CASE_FOLD_EN
        if (match_count !== 4'd1) begin bad++; $display("FAIL fold_count got=%0d exp=1", match_count); end
`else
        if (match_count !== 4'd0) begin bad++; $display("FAIL fold_count got=%0d exp=0", match_count); end
`endif
    endtask

    task automatic test_saturate();
        do_reset(2'b01);
        for (int p = 0; p < 17; p++) begin
            for (int i = 0; i < 7; i++) drive(1'b0, 2'b01, PB[i], 1'b1);
            total++;
            if (match !== 1'b1) begin bad++; $display("FAIL sat_match[%0d] got=%b exp=1", p, match); end
        end
        total++;
        if (match_count !== 4'hF) begin bad++; $display("FAIL sat_count got=%0d exp=15", match_count); end
    endtask

    task automatic test_random();
        string      alpha;
        logic [1:0] sel;
        logic [7:0] b;
        logic       r, v;
        alpha = "GQuatemlzxgqU";
        sel = 2'b00;
        do_reset(sel);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) sel = 2'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) b = ph(^m_sel, m_idx);
            else b = alpha[$urandom_range(0, alpha.len() - 1)];
            if ($urandom_range(0, 9) == 0) b = b ^ 8'h20;
            drive(r, sel, b, v);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL rand_model[%0d] got=%h exp=%h", i, obs, expv()); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        select     = 2'b00;
        data_in    = 8'h00;
        data_valid = 1'b0;
        m_sel = 2'b00; m_locked = 1'b0; m_match = 1'b0; m_ferr = 1'b0; m_idx = 0; m_cnt = 0;
        test_reset();
        test_phrase_a();
        test_phrase_b_qqq();
        test_frame_err();
        test_valid_gaps();
        test_select_change();
        test_case_fold();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
